// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM encoding,
// default timeout and the address/data widths of the I2C master.
package i2c_pkg;

    localparam int I2C_ADDR_W          = 7;
    localparam int I2C_DATA_W          = 8;
    localparam int TIMEOUT_CYC_DEFAULT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward
// from ptr+1, wrapping modulo NUM_REQ. One-hot and index outputs.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_req
);

    int               k;
    logic             found;
    logic [PTR_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        k         = 0;
        sel       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k   = (int'(ptr) + i) % NUM_REQ;
            sel = PTR_W'(k);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant,
// held enable/ready launch handshake, FIFO routing, done/timeout reporting.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int TO_W        = 16
) (
    input  logic                            clk,
    input  logic                            i2c_reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [I2C_DATA_W*NUM_REQ-1:0]   req_tx_data,
    input  logic [NUM_REQ-1:0]              req_tx_empty,
    output logic [NUM_REQ-1:0]              req_tx_rd_en,
    output logic [NUM_REQ-1:0]              req_rx_wr_en,
    output logic [I2C_DATA_W-1:0]           req_rx_data,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [I2C_ADDR_W-1:0]           m_addr,
    output logic                            m_rw,
    output logic                            m_enable,
    output logic [I2C_DATA_W-1:0]           m_data_in,
    output logic                            m_fifo_tx_empty,
    input  logic                            m_ready,
    input  logic                            m_fifo_tx_rd_en,
    input  logic                            m_fifo_rx_wr_en,
    input  logic [I2C_DATA_W-1:0]           m_data_out
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    arb_state_t              state_reg;
    logic [NUM_REQ-1:0]      grant_reg;
    logic [PTR_W-1:0]        gidx_reg;
    logic [PTR_W-1:0]        ptr_reg;
    logic [I2C_ADDR_W-1:0]   addr_reg;
    logic                    rw_reg;
    logic                    enable_reg;
    logic [NUM_REQ-1:0]      done_reg;
    logic [NUM_REQ-1:0]      err_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [TO_W-1:0]         to_cnt_next;

    logic [I2C_ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [I2C_DATA_W-1:0]   tx_arr   [NUM_REQ];

    logic [NUM_REQ-1:0]      arb_req;
    logic [NUM_REQ-1:0]      win_grant;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_any;
    logic                    granted;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
            assign tx_arr[gi]       = req_tx_data[gi*I2C_DATA_W +: I2C_DATA_W];
            // Strobes reach only the granted requester; with no grant they vanish.
            assign req_tx_rd_en[gi] = grant_reg[gi] & m_fifo_tx_rd_en;
            assign req_rx_wr_en[gi] = grant_reg[gi] & m_fifo_rx_wr_en;
        end
    endgenerate

    // A requester whose err pulse is still visible has not yet had the
    // chance to drop its request, so it is kept out of this arbitration.
    assign arb_req = req_valid & ~(done_reg | err_reg);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (arb_req),
        .ptr       (ptr_reg),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .any_req   (win_any)
    );

    assign to_cnt_next = to_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            gidx_reg   <= '0;
            ptr_reg    <= PTR_RST;
            addr_reg   <= '0;
            rw_reg     <= 1'b0;
            enable_reg <= 1'b0;
            done_reg   <= '0;
            err_reg    <= '0;
            to_cnt_reg <= '0;
        end else begin
            done_reg <= '0;
            err_reg  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (m_ready && win_any) begin
                        grant_reg  <= win_grant;
                        gidx_reg   <= win_idx;
                        addr_reg   <= addr_arr[win_idx];
                        rw_reg     <= req_rw[win_idx];
                        enable_reg <= 1'b1;
                        to_cnt_reg <= '0;
                        state_reg  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH, ST_WAIT_DONE: begin
                    to_cnt_reg <= to_cnt_next;
                    if (to_cnt_next == TO_LIMIT) begin
                        enable_reg <= 1'b0;
                        err_reg    <= grant_reg;
                        grant_reg  <= '0;
                        ptr_reg    <= gidx_reg;
                        state_reg  <= ST_IDLE;
                    end else if (state_reg == ST_LAUNCH) begin
                        // Enable stays up until the master, on its slow clock, goes busy.
                        if (!m_ready) begin
                            enable_reg <= 1'b0;
                            state_reg  <= ST_WAIT_DONE;
                        end
                    end else if (m_ready) begin
                        done_reg  <= grant_reg;
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    grant_reg <= '0;
                    ptr_reg   <= gidx_reg;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        granted         = |grant_reg;
        m_data_in       = granted ? tx_arr[gidx_reg] : '0;
        m_fifo_tx_empty = granted ? req_tx_empty[gidx_reg] : 1'b1;
    end

    assign req_rx_data = m_data_out;
    assign req_grant   = grant_reg;
    assign req_done    = done_reg;
    assign req_err     = err_reg;
    assign m_addr      = addr_reg;
    assign m_rw        = rw_reg;
    assign m_enable    = enable_reg;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one i2c_master instance between NUM_REQ requesters, e.g. the APB register bank plus autonomous pollers. It takes per-requester transaction requests, grants them round-robin, and launches the master with a held enable/ready handshake. While a requester holds the grant, its TX/RX byte FIFOs are routed to the master. It reports completion or timeout per requester.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_CYC, 65535, clk cycles allowed from launch to master idle before abort
TO_W, 16, timeout counter width; must hold TIMEOUT_CYC

Ports:
clk  input  1  system clock
i2c_reset_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  request pending, one per requester; held until req_done or req_err
req_addr  input  7*NUM_REQ  7-bit slave address per requester, requester i at [7i+6:7i]
req_rw  input  NUM_REQ  1 = read, 0 = write
req_tx_data  input  8*NUM_REQ  TX FIFO head byte per requester
req_tx_empty  input  NUM_REQ  TX FIFO empty per requester
req_tx_rd_en  output  NUM_REQ  TX FIFO pop, routed to the granted requester only
req_rx_wr_en  output  NUM_REQ  RX FIFO push, routed to the granted requester only
req_rx_data  output  8  RX byte, shared by all requesters
req_grant  output  NUM_REQ  one-hot grant
req_done  output  NUM_REQ  1-cycle completion pulse
req_err  output  NUM_REQ  1-cycle timeout pulse
m_addr  output  7  to master addr
m_rw  output  1  to master rw
m_enable  output  1  to master i2c_enable
m_data_in  output  8  to master i2c_data_in
m_fifo_tx_empty  output  1  to master fifo_tx_empty
m_ready  input  1  from master i2c_ready
m_fifo_tx_rd_en  input  1  from master
m_fifo_rx_wr_en  input  1  from master
m_data_out  input  8  from master i2c_data_out

Behaviour:
- Reset values: req_grant=0, req_done=0, req_err=0, m_enable=0, m_addr=0, m_rw=0, rr pointer=NUM_REQ-1, state=IDLE, timeout counter=0.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE: if m_ready=1 and any req_valid, register the winner, load m_addr/m_rw from it, set req_grant one-hot, go to LAUNCH. The winner is the first set bit scanning from ptr+1 upward, wrapping modulo NUM_REQ. If m_ready=0, stay in IDLE.
- LAUNCH: m_enable=1 and held. The master samples on its divided clock, so enable must persist. When m_ready=0 is observed, drop m_enable and go to WAIT_DONE.
- WAIT_DONE: when m_ready returns to 1, go to RELEASE.
- RELEASE: pulse req_done[g] for 1 cycle, clear req_grant, set ptr=g, return to IDLE. The next grant comes no earlier than the cycle after RELEASE.
- Timeout counter: cleared on entry to LAUNCH, increments in LAUNCH and WAIT_DONE. When it reaches TIMEOUT_CYC: drop m_enable, pulse req_err[g] (not req_done), clear the grant, update ptr, go to IDLE.
- Routing, combinational on the registered grant:
  - m_data_in = req_tx_data[g]
  - m_fifo_tx_empty = req_tx_empty[g]
  - req_tx_rd_en[g] = m_fifo_tx_rd_en
  - req_rx_wr_en[g] = m_fifo_rx_wr_en
  - req_rx_data = m_data_out
- With no grant: m_fifo_tx_empty=1, m_data_in=0, and all req_tx_rd_en/req_rx_wr_en are 0. Any master strobe arriving in that condition is dropped.
- m_addr/m_rw are stable from LAUNCH through RELEASE; a requester changing req_addr mid-transaction has no effect.
- If req_valid[g] drops while granted, the transaction still runs to completion; done still pulses.
- Simultaneous requests: exactly one grant per arbitration. Each requester waits at most NUM_REQ-1 transactions.
- Reset mid-transaction: immediate return to reset values; grant released without a done pulse.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (IDLE, LAUNCH, WAIT_DONE, RELEASE)
  - the default TIMEOUT_CYC
  - address/data width constants (7, 8)
- Sub-module rr_arbiter (NUM_REQ): purely combinational round-robin winner selection from req vector and ptr, with one-hot output. The FSM, timeout counter and routing stay in the top module.

Test Plan:
- Single write: NUM_REQ=2; req0 valid, addr 0x50, rw=0, 2 TX bytes; master model acks. Expect:
  - grant=01 and m_addr=0x50 next cycle;
  - m_enable held until m_ready=0;
  - two req_tx_rd_en[0] pulses;
  - req_done[0] once; req_tx_rd_en[1] never.
- Simultaneous requests: req0 and req1 valid from reset. Expect grant order 01, 10, 01, 10 over 4 transactions, with ptr wrapping.
- Read routing: req1 rw=1 with 3 RX bytes 0xA5, 0x3C, 0xFF. Expect three req_rx_wr_en[1] pulses with req_rx_data matching in order; req_rx_wr_en[0]=0 throughout.
- Timeout: TIMEOUT_CYC=100, master model holds m_ready=0. Expect req_err pulse on cycle 100 after LAUNCH, no req_done, grant cleared, next requester served.
- Reset mid-WAIT_DONE: assert i2c_reset_n=0. Expect grant=0 and m_enable=0 asynchronously; no done/err pulse; a fresh request is accepted after release.
- Busy master: m_ready=0 in IDLE while req0 is valid. Expect no grant until m_ready=1.
